// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and the data-memory bus.
// Accesses that cross a bus-word boundary are issued as two aligned beats.
// Load data is reassembled and sign- or zero-extended before the response.
module mem_access_unit #(
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 32,
  parameter bit ALLOW_UNALIGNED = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_ack,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err
);
  localparam int NB   = DATA_W / 8;
  localparam int OFFW = $clog2(NB);
  localparam int BEW  = 2 * NB;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              signed_q, we_q, err_q, split_q;
  logic [DATA_W-1:0] wdata_q, raw0_q, raw1_q;

  // Replace every byte above the access length with the fill value; the
  // fill ripples upward so each byte copies the top bit of the one below.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d,
                                               input logic [1:0] sz,
                                               input logic sgn);
    logic [DATA_W-1:0] r;
    r = d;
    for (int b = 1; b < NB; b++) begin
      if (b >= (1 << sz)) r[8*b +: 8] = sgn ? {8{r[8*b-1]}} : 8'h00;
    end
    return r;
  endfunction

  // Classification of the incoming request
  logic [OFFW-1:0] req_off;
  logic [3:0]      req_len;
  logic            req_mis, req_split, req_bad;

  assign req_off   = req_addr[OFFW-1:0];
  assign req_len   = 4'd1 << req_size;
  assign req_mis   = (4'(req_off) & (req_len - 4'd1)) != 4'd0;
  assign req_split = (5'(req_off) + 5'(req_len)) > 5'(NB);
  assign req_bad   = (req_len > 4'(NB)) || (req_mis && !ALLOW_UNALIGNED);

  // Lane shaping of the captured request: the double-width shifts give beat 0
  // in the low half and the spill-over for beat 1 in the high half.
  logic [OFFW-1:0]     off_q;
  logic [3:0]          len_q;
  logic [OFFW+2:0]     sh_q;
  logic [BEW-1:0]      be_wide;
  logic [2*DATA_W-1:0] wd_wide;
  logic [ADDR_W-1:0]   base_q;
  logic [DATA_W-1:0]   merged;

  assign off_q   = addr_q[OFFW-1:0];
  assign len_q   = 4'd1 << size_q;
  assign sh_q    = {off_q, 3'b000};
  assign be_wide = ((BEW'(1) << len_q) - BEW'(1)) << off_q;
  assign wd_wide = {{DATA_W{1'b0}}, wdata_q} << sh_q;
  assign base_q  = {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}};
  assign merged  = DATA_W'({raw1_q, raw0_q} >> sh_q);

  // State register; reset abandons any beat in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Request capture at acceptance and read-data capture on each acked beat
  always_ff @(posedge clk) begin
    if (state_q == IDLE && req_valid) begin
      addr_q   <= req_addr;
      size_q   <= req_size;
      signed_q <= req_signed;
      we_q     <= req_we;
      wdata_q  <= req_wdata;
      err_q    <= req_bad;
      split_q  <= req_split;
    end
    if (state_q == BEAT0 && bus_ack) raw0_q <= bus_rdata;
    if (state_q == BEAT1 && bus_ack) raw1_q <= bus_rdata;
  end

  // Next state plus bus and response outputs; everything is zero outside its state
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_be    = '0;
    bus_wdata = '0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_bad ? RESP : BEAT0;
      end
      BEAT0: begin
        bus_req   = 1'b1;
        bus_we    = we_q;
        bus_addr  = base_q;
        bus_be    = be_wide[NB-1:0];
        bus_wdata = wd_wide[DATA_W-1:0];
        if (bus_ack) state_d = split_q ? BEAT1 : RESP;
      end
      BEAT1: begin
        bus_req   = 1'b1;
        bus_we    = we_q;
        bus_addr  = base_q + ADDR_W'(NB);
        bus_be    = be_wide[BEW-1:NB];
        bus_wdata = wd_wide[2*DATA_W-1:DATA_W];
        if (bus_ack) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        if (!err_q && !we_q) rsp_data = extend(merged, size_q, signed_q);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: three instances (32-bit unaligned-capable,
// 32-bit strict, 64-bit) share one driver and one bus responder.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  vld;
  logic        req_we, req_signed, bus_ack;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, bus_rdata;
  int          sel;

  logic a_ready, a_breq, a_bwe, a_rv, a_rerr;
  logic [31:0] a_baddr, a_bwd, a_rd;
  logic [3:0]  a_be;
  logic n_ready, n_breq, n_bwe, n_rv, n_rerr;
  logic [31:0] n_baddr, n_bwd, n_rd;
  logic [3:0]  n_be;
  logic w_ready, w_breq, w_bwe, w_rv, w_rerr;
  logic [31:0] w_baddr;
  logic [63:0] w_bwd, w_rd;
  logic [7:0]  w_be;

  logic        o_req_ready, o_bus_req, o_bus_we, o_rsp_valid, o_rsp_err;
  logic [31:0] o_bus_addr;
  logic [7:0]  o_bus_be;
  logic [63:0] o_bus_wdata, o_rsp_data;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .ALLOW_UNALIGNED(1'b1)) u32 (
    .clk(clk), .reset(reset), .req_valid(vld[0]), .req_ready(a_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .bus_req(a_breq), .bus_we(a_bwe), .bus_addr(a_baddr), .bus_be(a_be), .bus_wdata(a_bwd),
    .bus_rdata(bus_rdata[31:0]), .bus_ack(bus_ack), .rsp_valid(a_rv), .rsp_data(a_rd), .rsp_err(a_rerr));

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .ALLOW_UNALIGNED(1'b0)) u32n (
    .clk(clk), .reset(reset), .req_valid(vld[1]), .req_ready(n_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .bus_req(n_breq), .bus_we(n_bwe), .bus_addr(n_baddr), .bus_be(n_be), .bus_wdata(n_bwd),
    .bus_rdata(bus_rdata[31:0]), .bus_ack(bus_ack), .rsp_valid(n_rv), .rsp_data(n_rd), .rsp_err(n_rerr));

  mem_access_unit #(.DATA_W(64), .ADDR_W(32), .ALLOW_UNALIGNED(1'b1)) u64 (
    .clk(clk), .reset(reset), .req_valid(vld[2]), .req_ready(w_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .bus_req(w_breq), .bus_we(w_bwe), .bus_addr(w_baddr), .bus_be(w_be), .bus_wdata(w_bwd),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .rsp_valid(w_rv), .rsp_data(w_rd), .rsp_err(w_rerr));

  initial forever #5 clk = ~clk;

  always_comb begin
    case (sel)
      1: begin
        o_req_ready = n_ready; o_bus_req = n_breq; o_bus_we = n_bwe; o_bus_addr = n_baddr;
        o_bus_be = {4'b0, n_be}; o_bus_wdata = {32'b0, n_bwd};
        o_rsp_valid = n_rv; o_rsp_data = {32'b0, n_rd}; o_rsp_err = n_rerr;
      end
      2: begin
        o_req_ready = w_ready; o_bus_req = w_breq; o_bus_we = w_bwe; o_bus_addr = w_baddr;
        o_bus_be = w_be; o_bus_wdata = w_bwd;
        o_rsp_valid = w_rv; o_rsp_data = w_rd; o_rsp_err = w_rerr;
      end
      default: begin
        o_req_ready = a_ready; o_bus_req = a_breq; o_bus_we = a_bwe; o_bus_addr = a_baddr;
        o_bus_be = {4'b0, a_be}; o_bus_wdata = {32'b0, a_bwd};
        o_rsp_valid = a_rv; o_rsp_data = {32'b0, a_rd}; o_rsp_err = a_rerr;
      end
    endcase
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Backing memory: every aligned address holds a fixed scrambled 64-bit word
  function automatic logic [63:0] mem_word(input logic [31:0] a);
    logic [31:0] h0, h1;
    h0 = a * 32'h9E3779B9 ^ 32'h5A5A1234;
    h1 = (a + 32'h1357) * 32'h85EBCA6B;
    return {h0, h1};
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a, input int nb);
    logic [63:0] w;
    int          lane;
    w    = mem_word(a & ~32'(nb - 1));
    lane = int'(a % 32'(nb));
    return w[8*lane +: 8];
  endfunction

  // Observations of one transaction
  logic [31:0] b_addr [4];
  logic [7:0]  b_be   [4];
  logic [63:0] b_wd   [4];
  logic        b_we   [4];
  int          nbeats, wait_total, lat;
  bit          got_rsp;
  logic [63:0] rsp_d;
  logic        rsp_e;
  logic [63:0] rd_q [$];

  task automatic run_txn(input int s, input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [63:0] wdata, input bit rwait);
    int cyc, w, wcnt;
    bit inbeat;
    sel = s;
    @(negedge clk);
    chk("ready_before", 64'(o_req_ready), 64'd1);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    bus_ack = 1'($urandom_range(0, 1));
    vld[s] = 1'b1;
    @(posedge clk); #1;
    vld = '0; bus_ack = 1'b0;
    req_addr = $urandom; req_wdata = {$urandom, $urandom};
    req_size = 2'($urandom); req_we = 1'($urandom); req_signed = 1'($urandom);
    nbeats = 0; wait_total = 0; inbeat = 0; got_rsp = 0; cyc = 0; w = 0; wcnt = 0;
    while (!got_rsp && cyc < 40) begin
      @(negedge clk);
      cyc++;
      bus_ack = 1'b0;
      bus_rdata = {$urandom, $urandom};
      if (o_rsp_valid) begin
        got_rsp = 1; lat = cyc; rsp_d = o_rsp_data; rsp_e = o_rsp_err;
      end else if (o_bus_req && nbeats < 4) begin
        if (!inbeat) begin
          b_addr[nbeats] = o_bus_addr; b_be[nbeats] = o_bus_be;
          b_wd[nbeats] = o_bus_wdata; b_we[nbeats] = o_bus_we;
          inbeat = 1; wcnt = 0;
          w = rwait ? $urandom_range(0, 2) : 0;
        end else begin
          chk("hold_addr", 64'(o_bus_addr), 64'(b_addr[nbeats]));
          chk("hold_be", 64'(o_bus_be), 64'(b_be[nbeats]));
          chk("hold_wdata", o_bus_wdata, b_wd[nbeats]);
          chk("hold_we", 64'(o_bus_we), 64'(b_we[nbeats]));
        end
        if (wcnt == w) begin
          bus_ack = 1'b1;
          if (rd_q.size() > 0) bus_rdata = rd_q.pop_front();
          else                 bus_rdata = mem_word(o_bus_addr);
          nbeats++; inbeat = 0;
        end else begin
          wcnt++; wait_total++;
        end
      end
    end
    chk("rsp_seen", 64'(got_rsp), 64'd1);
    if (got_rsp) begin
      // A request offered during the response cycle must not be taken
      req_we = 1'b0; req_size = 2'd0; req_addr = $urandom;
      vld[s] = 1'b1;
      @(posedge clk); #1;
      vld = '0;
      @(negedge clk);
      chk("rsp_one_cycle", 64'(o_rsp_valid), 64'd0);
      chk("no_accept_in_resp", 64'(o_bus_req), 64'd0);
      chk("ready_after", 64'(o_req_ready), 64'd1);
    end
  endtask

  // Reference: byte-level view of the access, independent of beat mechanics
  task automatic model_chk(input int s, input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [63:0] wdata);
    int nb, len, off, nbx, cnt, idx;
    bit err;
    logic [31:0] a;
    logic [63:0] exp;
    nb  = (s == 2) ? 8 : 4;
    len = 1 << size;
    off = int'(addr % 32'(nb));
    err = (len > nb) || ((s == 1) && (off % len) != 0);
    nbx = err ? 0 : ((off + len > nb) ? 2 : 1);
    chk("rsp_err", 64'(rsp_e), 64'(err));
    chk("beats", 64'(nbeats), 64'(nbx));
    chk("latency", 64'(lat), err ? 64'd1 : 64'(1 + nbx + wait_total));
    cnt = 0;
    for (int k = 0; k < nbeats && k < 4; k++) begin
      chk("beat_addr", 64'(b_addr[k]), 64'((addr & ~32'(nb - 1)) + 32'(k * nb)));
      chk("beat_we", 64'(b_we[k]), 64'(we));
      for (int l = 0; l < nb; l++) begin
        if (b_be[k][l]) begin
          a = b_addr[k] + 32'(l);
          idx = int'(a - addr);
          cnt++;
          chk("lane_in_range", 64'(idx >= 0 && idx < len), 64'd1);
          if (we && idx >= 0 && idx < len)
            chk("store_byte", 64'(b_wd[k][8*l +: 8]), 64'(wdata[8*idx +: 8]));
        end
      end
    end
    chk("lane_count", 64'(cnt), err ? 64'd0 : 64'(len));
    exp = '0;
    if (!we && !err) begin
      for (int i = 0; i < len; i++) exp[8*i +: 8] = byte_at(addr + 32'(i), nb);
      if (len < nb && sgn && exp[8*len-1])
        for (int j = 8 * len; j < 8 * nb; j++) exp[j] = 1'b1;
    end
    chk("rsp_data", rsp_d, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vld = '0; bus_ack = 1'b0; bus_rdata = '0; sel = 0;
    req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      chk("rst_bus_req", 64'(o_bus_req), 64'd0);
      chk("rst_bus_we", 64'(o_bus_we), 64'd0);
      chk("rst_bus_addr", 64'(o_bus_addr), 64'd0);
      chk("rst_bus_be", 64'(o_bus_be), 64'd0);
      chk("rst_bus_wdata", o_bus_wdata, 64'd0);
      chk("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
      chk("rst_rsp_err", 64'(o_rsp_err), 64'd0);
      chk("rst_rsp_data", o_rsp_data, 64'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      chk("rst_ready", 64'(o_req_ready), 64'd1);
    end

    // Signed byte load at the top lane
    rd_q.push_back(64'h0000_0000_80FF_1234);
    run_txn(0, 1'b0, 2'd0, 1'b1, 32'h1003, 64'd0, 1'b0);
    chk("lb_addr", 64'(b_addr[0]), 64'h1000);
    chk("lb_be", 64'(b_be[0]), 64'h8);
    chk("lb_data", rsp_d, 64'hFFFF_FF80);
    chk("lb_lat", 64'(lat), 64'd2);

    // Unsigned half load in the upper half-word
    rd_q.push_back(64'h0000_0000_BEEF_0000);
    run_txn(0, 1'b0, 2'd1, 1'b0, 32'h1002, 64'd0, 1'b0);
    chk("lhu_be", 64'(b_be[0]), 64'hC);
    chk("lhu_data", rsp_d, 64'h0000_BEEF);

    // Word load straddling two bus words
    rd_q.push_back(64'h0000_0000_AA00_0000);
    rd_q.push_back(64'h0000_0000_0033_2211);
    run_txn(0, 1'b0, 2'd2, 1'b0, 32'h1003, 64'd0, 1'b0);
    chk("lw_split_beats", 64'(nbeats), 64'd2);
    chk("lw_b0_addr", 64'(b_addr[0]), 64'h1000);
    chk("lw_b0_be", 64'(b_be[0]), 64'h8);
    chk("lw_b1_addr", 64'(b_addr[1]), 64'h1004);
    chk("lw_b1_be", 64'(b_be[1]), 64'h7);
    chk("lw_split_data", rsp_d, 64'h3322_11AA);
    chk("lw_split_lat", 64'(lat), 64'd3);

    // Half store straddling two bus words
    run_txn(0, 1'b1, 2'd1, 1'b0, 32'h1003, 64'h0000_BBCC, 1'b0);
    chk("sh_b0_be", 64'(b_be[0]), 64'h8);
    chk("sh_b0_byte", 64'(b_wd[0][31:24]), 64'hCC);
    chk("sh_b1_be", 64'(b_be[1]), 64'h1);
    chk("sh_b1_byte", 64'(b_wd[1][7:0]), 64'hBB);
    chk("sh_we", 64'(b_we[0] & b_we[1]), 64'd1);
    chk("sh_data", rsp_d, 64'd0);

    // Misaligned word load with splitting disabled
    run_txn(1, 1'b0, 2'd2, 1'b0, 32'h1002, 64'd0, 1'b0);
    chk("strict_beats", 64'(nbeats), 64'd0);
    chk("strict_err", 64'(rsp_e), 64'd1);
    chk("strict_lat", 64'(lat), 64'd1);
    chk("strict_data", rsp_d, 64'd0);

    // Reset while the first beat waits for an ack
    sel = 0;
    @(negedge clk);
    req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h2000;
    vld[0] = 1'b1;
    @(posedge clk); #1;
    vld = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_wait_req", 64'(o_bus_req), 64'd1);
    end
    #2 reset = 1'b0;
    #1;
    chk("rst_drop_req", 64'(o_bus_req), 64'd0);
    chk("rst_drop_be", 64'(o_bus_be), 64'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", 64'(o_rsp_valid), 64'd0);
    end
    @(posedge clk); #2 reset = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", 64'(o_req_ready), 64'd1);
    chk("rst_release_rsp", 64'(o_rsp_valid), 64'd0);

    // 64-bit dword signed load passes through unchanged
    rd_q.push_back(64'h8123_4567_89AB_CDEF);
    run_txn(2, 1'b0, 2'd3, 1'b1, 32'h8, 64'd0, 1'b0);
    chk("ld_addr", 64'(b_addr[0]), 64'h8);
    chk("ld_be", 64'(b_be[0]), 64'hFF);
    chk("ld_data", rsp_d, 64'h8123_4567_89AB_CDEF);
    chk("ld_err", 64'(rsp_e), 64'd0);

    // Randomised traffic across all three instances with random ack waits
    for (int t = 0; t < 300; t++) begin
      int          s;
      logic        we, sg;
      logic [1:0]  sz;
      logic [31:0] ad;
      logic [63:0] wd;
      s  = $urandom_range(0, 2);
      we = 1'($urandom);
      sg = 1'($urandom);
      sz = 2'($urandom);
      ad = $urandom_range(0, 32'hFFFF);
      wd = {$urandom, $urandom};
      run_txn(s, we, sz, sg, ad, wd, 1'b1);
      model_chk(s, we, sz, sg, ad, wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
